// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared types and timing constants for the NeoPixel controller
package neopixel_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_t;

    typedef enum logic [1:0] {
        LATCH = 2'd0,
        IDLE  = 2'd1,
        SEND  = 2'd2
    } ctrl_state_t;

    localparam int DEF_NUM_PIXELS   = 5;
    localparam int DEF_T0H_CYCLES   = 20;
    localparam int DEF_T1H_CYCLES   = 40;
    localparam int DEF_BIT_CYCLES   = 62;
    localparam int DEF_RESET_CYCLES = 2500;
    localparam int BITS_PER_PIXEL   = 24;

    // Wire order inside a pixel is green, red, blue; byte_sel is bit_index[4:3].
    function automatic color_t wire_channel(input logic [1:0] byte_sel);
        case (byte_sel)
            2'd0:    return GREEN;
            2'd1:    return RED;
            default: return BLUE;
        endcase
    endfunction

endpackage

// File: rtl/neo_color_mem.sv
// rtl/neo_color_mem.sv - per-pixel RGB colour store with synchronous clear
module neo_color_mem
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [2:0] wr_pixel,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_pixel,
    input  logic [1:0] rd_color,
    output logic [7:0] rd_data
);

    logic [7:0] mem [NUM_PIXELS][3];
    logic       wr_ok;
    logic       rd_ok;

    // Out-of-range pixels and the invalid channel code are silently dropped.
    assign wr_ok = wr_en && ({1'b0, wr_pixel} < 4'(NUM_PIXELS)) && (wr_color != 2'd3);
    assign rd_ok = ({1'b0, rd_pixel} < 4'(NUM_PIXELS)) && (rd_color != 2'd3);

    // Storage: clear wins over a write in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    mem[p][c] <= 8'h00;
                end
            end
        end else if (wr_ok) begin
            mem[wr_pixel][wr_color] <= wr_data;
        end
    end

    // Combinational read so the serialiser sees the current byte without a pipeline stage.
    always_comb begin
        rd_data = 8'h00;
        if (rd_ok) begin
            rd_data = mem[rd_pixel][rd_color];
        end
    end

endmodule

// File: rtl/neopixel_controller.sv
// rtl/neopixel_controller.sv - colour memory plus WS2812 serialiser with latch period
module neopixel_controller
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       load_color,
    input  logic       send_it,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       neo_data
);

    localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0H_LEN    = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_LEN    = CNT_W'(T1H_CYCLES);
    localparam logic [4:0]       BIDX_LAST  = 5'(BITS_PER_PIXEL - 1);
    localparam logic [2:0]       PIX_LAST   = 3'(NUM_PIXELS - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_next;
    logic [4:0]       bit_cnt;
    logic [2:0]       pix_cnt;
    logic [2:0]       bit_pos;
    color_t           rd_color;
    logic [7:0]       rd_byte;
    logic             cur_bit;
    logic [CNT_W-1:0] high_len;
    logic             mem_wr;

    // Loads are only honoured while the controller advertises ready_to_load.
    assign mem_wr   = load_color && (state == IDLE);
    assign rd_color = wire_channel(bit_cnt[4:3]);
    assign bit_pos  = 3'd7 - bit_cnt[2:0];
    assign cur_bit  = rd_byte[bit_pos];
    assign high_len = cur_bit ? T1H_LEN : T0H_LEN;
    assign cyc_next = cyc_cnt + CNT_W'(1);

    neo_color_mem #(
        .NUM_PIXELS (NUM_PIXELS)
    ) u_mem (
        .clock    (clock),
        .clear    (reset),
        .wr_en    (mem_wr),
        .wr_pixel (pixel_index),
        .wr_color (color_index),
        .wr_data  (color_level),
        .rd_pixel (pix_cnt),
        .rd_color (rd_color),
        .rd_data  (rd_byte)
    );

    // Controller FSM: counters address the bit on the wire this cycle; neo_data is
    // computed one cycle ahead from the next counter position so it lands registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= LATCH;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            neo_data      <= 1'b0;
            ready_to_load <= 1'b0;
            ready_to_send <= 1'b0;
        end else begin
            case (state)
                LATCH: begin
                    neo_data <= 1'b0;
                    if (cyc_cnt == LATCH_LAST) begin
                        state         <= IDLE;
                        cyc_cnt       <= '0;
                        ready_to_load <= 1'b1;
                        ready_to_send <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_next;
                    end
                end

                IDLE: begin
                    if (send_it) begin
                        state         <= SEND;
                        cyc_cnt       <= '0;
                        bit_cnt       <= '0;
                        pix_cnt       <= '0;
                        neo_data      <= 1'b1;
                        ready_to_load <= 1'b0;
                        ready_to_send <= 1'b0;
                    end
                end

                SEND: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIDX_LAST) begin
                            bit_cnt <= '0;
                            if (pix_cnt == PIX_LAST) begin
                                // Last bit done: drop the line and start the latch.
                                state    <= LATCH;
                                pix_cnt  <= '0;
                                neo_data <= 1'b0;
                            end else begin
                                pix_cnt  <= pix_cnt + 3'd1;
                                neo_data <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            neo_data <= 1'b1;
                        end
                    end else begin
                        cyc_cnt  <= cyc_next;
                        neo_data <= (cyc_next < high_len);
                    end
                end

                default: begin
                    state    <= LATCH;
                    cyc_cnt  <= '0;
                    neo_data <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_controller.sv
// tb/tb_neopixel_controller.sv - directed self-checking bench for neopixel_controller
module tb_neopixel_controller;

    localparam int FRAME_BITS   = 120;
    localparam int BIT_CYCLES   = 62;
    localparam int FRAME_CYCLES = FRAME_BITS * BIT_CYCLES;
    localparam int LATCH_CYCLES = 2500;

    logic       clock;
    logic       reset;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       neo_data;

    int n_assert;
    int n_fail;

    logic           cap [FRAME_CYCLES];
    logic [119:0]   got;

    neopixel_controller dut (
        .clock         (clock),
        .reset         (reset),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .load_color    (load_color),
        .send_it       (send_it),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .neo_data      (neo_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_color(input logic [2:0] p, input logic [1:0] c, input logic [7:0] lvl);
        pixel_index = p;
        color_index = c;
        color_level = lvl;
        load_color  = 1'b1;
        @(negedge clock);
        load_color  = 1'b0;
    endtask

    task automatic check_latch(input string tag);
        int viol;
        viol = 0;
        for (int i = 0; i < LATCH_CYCLES; i++) begin
            if (neo_data !== 1'b0 || ready_to_load !== 1'b0 || ready_to_send !== 1'b0) viol++;
            @(negedge clock);
        end
        check({tag, "_latch_low"}, viol, 0);
        check({tag, "_ready_to_load"}, ready_to_load, 1);
        check({tag, "_ready_to_send"}, ready_to_send, 1);
    endtask

    task automatic start_send(input logic with_load, input logic [2:0] p,
                              input logic [1:0] c, input logic [7:0] lvl);
        send_it     = 1'b1;
        load_color  = with_load;
        pixel_index = p;
        color_index = c;
        color_level = lvl;
        @(negedge clock);
        send_it    = 1'b0;
        load_color = 1'b0;
        check("send_first_high", neo_data, 1);
        check("send_ready_drop", ready_to_send, 0);
    endtask

    task automatic run_frame(input string tag, input logic pulse_inputs, input logic [119:0] exp);
        int viol;
        int bad;
        int hc;
        viol = 0;
        for (int i = 0; i < FRAME_CYCLES; i++) begin
            cap[i] = neo_data;
            if (ready_to_load !== 1'b0 || ready_to_send !== 1'b0) viol++;
            if (pulse_inputs && (i == 100 || i == 2000)) begin
                pixel_index = 3'd1;
                color_index = 2'd1;
                color_level = 8'hFF;
                load_color  = 1'b1;
            end else begin
                load_color  = 1'b0;
            end
            send_it = pulse_inputs && (i == 300);
            @(negedge clock);
        end
        load_color = 1'b0;
        send_it    = 1'b0;
        check({tag, "_ready_low_in_frame"}, viol, 0);
        bad = 0;
        got = '0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            hc = 0;
            for (int c = 0; c < BIT_CYCLES; c++) begin
                if (cap[b * BIT_CYCLES + c] === 1'b1) hc++;
            end
            for (int c = 0; c < BIT_CYCLES; c++) begin
                if (cap[b * BIT_CYCLES + c] !== (c < hc)) bad++;
            end
            if (hc == 40) got[119 - b] = 1'b1;
            else if (hc != 20) bad++;
        end
        check({tag, "_bit_shape"}, bad, 0);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("%s_byte%0d", tag, k), 32'(got[119 - 8 * k -: 8]), 32'(exp[119 - 8 * k -: 8]));
        end
        check_latch(tag);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        pixel_index = 3'd0;
        color_index = 2'd0;
        color_level = 8'h00;
        load_color  = 1'b0;
        send_it     = 1'b0;

        // Reset values, then the initial latch period.
        repeat (3) @(negedge clock);
        check("rst_neo_data", neo_data, 0);
        check("rst_ready_to_load", ready_to_load, 0);
        check("rst_ready_to_send", ready_to_send, 0);
        reset = 1'b0;
        check_latch("init");

        // Frame from cleared memory: 120 zero bits.
        start_send(1'b0, 3'd0, 2'd0, 8'h00);
        run_frame("zero", 1'b0, 120'h0);

        // Out-of-range pixel and invalid channel writes are dropped.
        write_color(3'd5, 2'd0, 8'h55);
        write_color(3'd7, 2'd2, 8'h33);
        write_color(3'd0, 2'd3, 8'h55);
        start_send(1'b0, 3'd0, 2'd0, 8'h00);
        run_frame("invalid", 1'b0, 120'h0);

        // Pixel 0: R=FF G=00 B=81, sent GRB.
        write_color(3'd0, 2'd0, 8'hFF);
        write_color(3'd0, 2'd1, 8'h00);
        write_color(3'd0, 2'd2, 8'h81);
        start_send(1'b0, 3'd0, 2'd0, 8'h00);
        run_frame("pix0", 1'b0, {24'h00FF81, 96'h0});

        // Load and send together; loads/sends during SEND must be ignored.
        start_send(1'b1, 3'd4, 2'd2, 8'hAA);
        run_frame("simul", 1'b1, {24'h00FF81, 88'h0, 8'hAA});

        // Reset in the middle of bit 50.
        start_send(1'b0, 3'd0, 2'd0, 8'h00);
        repeat (50 * BIT_CYCLES + 5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_neo_data", neo_data, 0);
        check("midrst_ready_to_load", ready_to_load, 0);
        check("midrst_ready_to_send", ready_to_send, 0);
        reset = 1'b0;
        check_latch("midrst");

        // Memory was cleared by the reset.
        start_send(1'b0, 3'd0, 2'd0, 8'h00);
        run_frame("postrst", 1'b0, 120'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
